// File: rtl/db_sense_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : db_sense_pkg
//  Purpose  : Shared state encoding, debounce width and sizing helper for the
//             daughterboard sense scanner.
//  Revision : 1.0 - initial release
// ============================================================================
package db_sense_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_PRECHARGE = 3'd1;
    localparam logic [STATE_W-1:0] ST_SETTLE    = 3'd2;
    localparam logic [STATE_W-1:0] ST_SAMPLE    = 3'd3;
    localparam logic [STATE_W-1:0] ST_UPDATE    = 3'd4;

    localparam int DB_CNT_W = 4;

    // Ceiling log2, never below 1 so a counter for a count of 1 still has a bit.
    function automatic int db_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/db_sense_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : db_sense_debounce
//  Purpose  : One channel's disagreement counter, presence flag and flip pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module db_sense_debounce
    import db_sense_pkg::*;
#(
    parameter int DEBOUNCE = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step,
    input  logic                raw,
    output logic                present,
    output logic                flip,
    output logic [DB_CNT_W-1:0] cnt
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            present <= 1'b0;
            flip    <= 1'b0;
            cnt     <= '0;
        end else begin
            flip <= 1'b0;
            if (step) begin
                if (raw != present) begin
                    if (cnt == CNT_LAST) begin
                        present <= ~present;
                        cnt     <= '0;
                        flip    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/db_sense_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : db_sense_scanner
//  Purpose  : Periodic float/settle/sample scanner with per-slot debounced
//             presence. Optional macro DB_SENSE_PRECHARGE_EN adds a drive-high
//             precharge phase before each float.
//  Revision : 1.0 - initial release
// ============================================================================
module db_sense_scanner
    import db_sense_pkg::*;
#(
    parameter int NUM_DB           = 4,
    parameter int SCAN_PERIOD      = 1024,
    parameter int SETTLE_CYCLES    = 16,
    parameter int DEBOUNCE         = 3,
    parameter int PRECHARGE_CYCLES = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              force_rescan_i,
    input  logic [NUM_DB-1:0] sense_i,
    output logic [NUM_DB-1:0] sense_o,
    output logic [NUM_DB-1:0] sense_oe,
    output logic [NUM_DB-1:0] present_o,
    output logic              change_o,
    output logic              scan_done_o
);

    localparam int PERIOD_W  = db_clog2(SCAN_PERIOD);
    localparam int PHASE_MAX = (SETTLE_CYCLES > PRECHARGE_CYCLES) ? SETTLE_CYCLES
                                                                   : PRECHARGE_CYCLES;
    localparam int PHASE_W   = db_clog2(PHASE_MAX);

    localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(SCAN_PERIOD - 1);
    localparam logic [PHASE_W-1:0]  SETTLE_LAST = PHASE_W'(SETTLE_CYCLES - 1);
`ifdef DB_SENSE_PRECHARGE_EN
    localparam logic [PHASE_W-1:0]  PRECHARGE_LAST = PHASE_W'(PRECHARGE_CYCLES - 1);
    localparam logic [STATE_W-1:0]  FIRST_SCAN_ST  = ST_PRECHARGE;
`else
    localparam logic [STATE_W-1:0]  FIRST_SCAN_ST  = ST_SETTLE;
`endif

    logic [STATE_W-1:0]  state;
    logic [STATE_W-1:0]  next_state;
    logic [PERIOD_W-1:0] period_cnt;
    logic [PHASE_W-1:0]  phase_cnt;
    logic [NUM_DB-1:0]   raw;
    logic [NUM_DB-1:0]   flip;
    logic                update_step;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A forced rescan and period expiry share one exit, so coincidence is harmless.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (enable_i && (force_rescan_i || (period_cnt == PERIOD_LAST))) begin
                    next_state = FIRST_SCAN_ST;
                end
            end
`ifdef DB_SENSE_PRECHARGE_EN
            ST_PRECHARGE: begin
                if (phase_cnt == PRECHARGE_LAST) begin
                    next_state = ST_SETTLE;
                end
            end
`endif
            ST_SETTLE: begin
                if (phase_cnt == SETTLE_LAST) begin
                    next_state = ST_SAMPLE;
                end
            end
            ST_SAMPLE: next_state = ST_UPDATE;
            ST_UPDATE: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        sense_oe = '0;
        sense_o  = '0;
`ifdef DB_SENSE_PRECHARGE_EN
        if (state == ST_PRECHARGE) begin
            sense_oe = '1;
            sense_o  = '1;
        end
`endif
    end

    // Counters restart whenever their state is left, so neither can wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_cnt  <= '0;
            phase_cnt   <= '0;
            raw         <= '0;
            scan_done_o <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && (next_state == ST_IDLE) && enable_i) begin
                period_cnt <= period_cnt + 1'b1;
            end else begin
                period_cnt <= '0;
            end

            if ((next_state == state) &&
                ((state == ST_SETTLE) || (state == ST_PRECHARGE))) begin
                phase_cnt <= phase_cnt + 1'b1;
            end else begin
                phase_cnt <= '0;
            end

            if (state == ST_SAMPLE) begin
                raw <= ~sense_i;
            end

            scan_done_o <= (state == ST_UPDATE);
        end
    end

    assign update_step = (state == ST_UPDATE);

    generate
        for (genvar ch = 0; ch < NUM_DB; ch++) begin : g_chan
            db_sense_debounce #(
                .DEBOUNCE (DEBOUNCE)
            ) u_deb (
                .clk     (clk_i),
                .rst     (rst_i),
                .step    (update_step),
                .raw     (raw[ch]),
                .present (present_o[ch]),
                .flip    (flip[ch]),
                .cnt     ()
            );
        end
    endgenerate

    assign change_o = |flip;

endmodule
`default_nettype wire

// File: tb/tb_db_sense_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_db_sense_scanner
//  Purpose  : Randomized self-checking bench for db_sense_scanner against a
//             scan-level presence model (honours DB_SENSE_PRECHARGE_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_db_sense_scanner;
    import db_sense_pkg::*;

    localparam int NUM_DB           = 4;
    localparam int SCAN_PERIOD      = 64;
    localparam int SETTLE_CYCLES    = 4;
    localparam int DEBOUNCE         = 3;
    localparam int PRECHARGE_CYCLES = 4;
`ifdef DB_SENSE_PRECHARGE_EN
    localparam int PRE_LEN = PRECHARGE_CYCLES;
`else
    localparam int PRE_LEN = 0;
`endif
    localparam int SCAN_LEN = PRE_LEN + SETTLE_CYCLES + 2;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              enable_i = 1'b1;
    logic              force_rescan_i = 1'b0;
    logic [NUM_DB-1:0] sense_i = '1;
    logic [NUM_DB-1:0] sense_o;
    logic [NUM_DB-1:0] sense_oe;
    logic [NUM_DB-1:0] present_o;
    logic              change_o;
    logic              scan_done_o;

    db_sense_scanner #(
        .NUM_DB           (NUM_DB),
        .SCAN_PERIOD      (SCAN_PERIOD),
        .SETTLE_CYCLES    (SETTLE_CYCLES),
        .DEBOUNCE         (DEBOUNCE),
        .PRECHARGE_CYCLES (PRECHARGE_CYCLES)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .force_rescan_i (force_rescan_i),
        .sense_i        (sense_i),
        .sense_o        (sense_o),
        .sense_oe       (sense_oe),
        .present_o      (present_o),
        .change_o       (change_o),
        .scan_done_o    (scan_done_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [NUM_DB-1:0] m_present;
    int                m_cnt [NUM_DB];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_present = '0;
        for (int ch = 0; ch < NUM_DB; ch++) m_cnt[ch] = 0;
    endtask

    // One scan's worth of presence evolution from the slot pull levels.
    task automatic model_scan(input logic [NUM_DB-1:0] pins, output logic chg);
        chg = 1'b0;
        for (int ch = 0; ch < NUM_DB; ch++) begin
            if ((!pins[ch]) != m_present[ch]) begin
                m_cnt[ch]++;
                if (m_cnt[ch] == DEBOUNCE) begin
                    m_present[ch] = ~m_present[ch];
                    m_cnt[ch]     = 0;
                    chg           = 1'b1;
                end
            end else begin
                m_cnt[ch] = 0;
            end
        end
    endtask

    // Starts at a negedge with the scanner in IDLE and a fresh period count.
    task automatic run_scan(input int force_at, input int drop_at);
        int   n = 0;
        int   stray = 0;
        int   oe_cyc = 0;
        int   bad_oe = 0;
        int   exp_int;
        logic chg;
        exp_int = ((force_at >= 0) && (force_at < SCAN_PERIOD)) ? force_at + 1 : SCAN_PERIOD;
        exp_int += SCAN_LEN;
        forever begin
            force_rescan_i = (n == force_at);
            if (n == drop_at) enable_i = 1'b0;
            @(negedge clk);
            n++;
            if (sense_oe != '0) oe_cyc++;
            if ((sense_o != sense_oe) || ((sense_oe != '0) && (sense_oe != '1))) bad_oe++;
            if (scan_done_o) break;
            if (change_o) stray++;
            if (n > exp_int + 20) break;
        end
        force_rescan_i = 1'b0;
        check_eq("scan_done_seen", 32'(scan_done_o), 1);
        check_eq("scan_interval", n, exp_int);
        check_eq("stray_change", stray, 0);
        check_eq("oe_cycles", oe_cyc, PRE_LEN);
        check_eq("oe_shape", bad_oe, 0);
        model_scan(sense_i, chg);
        check_eq("present", 32'(present_o), 32'(m_present));
        check_eq("change", 32'(change_o), 32'(chg));
    endtask

    task automatic do_reset();
        rst_i    = 1'b1;
        enable_i = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_present", 32'(present_o), 0);
        check_eq("rst_oe", 32'(sense_oe), 0);
        check_eq("rst_sense_o", 32'(sense_o), 0);
        check_eq("rst_done", 32'(scan_done_o), 0);
        check_eq("rst_change", 32'(change_o), 0);
        rst_i = 1'b0;
        model_reset();
    endtask

    initial begin
        int done_cnt;
        int chg_cnt;
        int oe_cnt;
        int pres_bad;
        logic [NUM_DB-1:0] s;

        model_reset();
        do_reset();

        // All slots empty for three scans.
        sense_i = 4'b1111;
        repeat (3) run_scan(-1, -1);

        // Slot 2 present: flag rises on the third scan.
        sense_i = 4'b1011;
        repeat (3) run_scan(-1, -1);
        check_eq("slot2_present", 32'(present_o), 32'h4);

        // One-scan glitch on slot 0.
        sense_i = 4'b1010;
        run_scan(-1, -1);
        check_eq("glitch_cnt1", 32'(dut.g_chan[0].u_deb.cnt), 1);
        sense_i = 4'b1011;
        run_scan(-1, -1);
        check_eq("glitch_cnt0", 32'(dut.g_chan[0].u_deb.cnt), 0);
        check_eq("glitch_present", 32'(present_o), 32'h4);

        // Forced rescan 5 cycles into IDLE, then one ignored during SETTLE.
        run_scan(5, -1);
        run_scan(SCAN_PERIOD + PRE_LEN + 2, -1);
        run_scan(SCAN_PERIOD - 1, -1);

        // Reset while in SETTLE.
        repeat (SCAN_PERIOD + PRE_LEN + 2) @(negedge clk);
        check_eq("pre_rst_state", 32'(dut.state), 32'(ST_SETTLE));
        check_eq("pre_rst_present", 32'(present_o), 32'h4);
        rst_i = 1'b1;
        @(negedge clk);
        check_eq("midrst_present", 32'(present_o), 0);
        check_eq("midrst_state", 32'(dut.state), 32'(ST_IDLE));
        check_eq("midrst_oe", 32'(sense_oe), 0);
        rst_i = 1'b0;
        model_reset();
        run_scan(-1, -1);

        // Bring slot 2 back, then hold with enable low.
        repeat (3) run_scan(-1, -1);
        enable_i = 1'b0;
        done_cnt = 0; chg_cnt = 0; oe_cnt = 0; pres_bad = 0;
        for (int i = 0; i < 5000; i++) begin
            force_rescan_i = (i == 100);
            @(negedge clk);
            if (scan_done_o) done_cnt++;
            if (change_o) chg_cnt++;
            if (sense_oe != '0) oe_cnt++;
            if (present_o != m_present) pres_bad++;
        end
        force_rescan_i = 1'b0;
        check_eq("hold_done", done_cnt, 0);
        check_eq("hold_change", chg_cnt, 0);
        check_eq("hold_oe", oe_cnt, 0);
        check_eq("hold_present", pres_bad, 0);
        enable_i = 1'b1;
        run_scan(-1, -1);

        // Enable drops mid-scan: the scan finishes, then scanning stops.
        run_scan(-1, SCAN_PERIOD + 1);
        done_cnt = 0;
        repeat (3 * SCAN_PERIOD) begin
            @(negedge clk);
            if (scan_done_o) done_cnt++;
        end
        check_eq("drop_hold_done", done_cnt, 0);
        enable_i = 1'b1;
        run_scan(-1, -1);

        // Randomized slot activity and rescan requests.
        s = sense_i;
        for (int it = 0; it < 40; it++) begin
            for (int ch = 0; ch < NUM_DB; ch++) begin
                if ($urandom_range(0, 3) == 0) s[ch] = ~s[ch];
            end
            sense_i = s;
            if ($urandom_range(0, 2) == 0) run_scan(-1, -1);
            else run_scan(int'($urandom_range(0, SCAN_PERIOD + 2)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/db_sense_scanner.md
# db_sense_scanner

Synthesizable, parametrised successor to the single-slot daughterboard sense logic. Scans NUM_DB daughterboard SENSE lines from the FPGA: periodically floats each line, waits for the board pull-up/pull-down to settle, samples it, and debounces the result into a stable per-slot presence flag. It sits between the ATRI sense pins, via top-level tristate buffers, and the slow-control register block, which consumes present_o and the change pulse.

## Interface
- NUM_DB, 4, number of daughterboard slots scanned in parallel
- SCAN_PERIOD, 1024, clk_i cycles in IDLE between scans (≥1)
- SETTLE_CYCLES, 16, cycles a line floats before it is sampled (≥1)
- DEBOUNCE, 3, consecutive disagreeing samples needed to flip a presence flag (1..15)
- PRECHARGE_CYCLES, 4, drive-high cycles before float (used only with DB_SENSE_PRECHARGE_EN)

- clk_i  in  1  system clock; the only clock
- rst_i  in  1  synchronous, active-high reset
- enable_i  in  1  scanning allowed
- force_rescan_i  in  1  one-cycle pulse; ends the current IDLE wait early
- sense_i  in  NUM_DB  sampled SENSE pin values
- sense_o  out  NUM_DB  SENSE drive value
- sense_oe  out  NUM_DB  SENSE drive enable (1 = FPGA drives)
- present_o  out  NUM_DB  debounced presence (1 = board present)
- change_o  out  1  one-cycle pulse when any present_o bit flips
- scan_done_o  out  1  one-cycle pulse at the end of each scan

## Operation
- Electrical convention: a present board pulls SENSE low, an absent slot is pulled high. Raw presence = !sense_i.
- All channels step together through one FSM.
- States:
  - IDLE: sense_oe=0. The period counter counts to SCAN_PERIOD-1, then moves to PRECHARGE (macro on) or SETTLE.
  - PRECHARGE: sense_oe=all 1, sense_o=all 1 for PRECHARGE_CYCLES, then SETTLE.
  - SETTLE: sense_oe=0 for SETTLE_CYCLES, then SAMPLE.
  - SAMPLE: one cycle. Registers !sense_i into raw[]. Next state is UPDATE.
  - UPDATE: one cycle. Debounce step, then IDLE with scan_done_o pulsed.
- Debounce, per channel:
  - If raw ≠ present_o, cnt increments.
  - If raw = present_o, cnt clears.
  - When cnt reaches DEBOUNCE, present_o flips, cnt clears and change_o pulses. change_o is the OR of all channels.
- force_rescan_i:
  - In IDLE, jumps to the next state on the following cycle.
  - Ignored in any other state.
  - Coincident with period expiry, it has the same effect (single transition).
- enable_i:
  - While low, the FSM holds in IDLE with the period counter cleared and sense_oe=0.
  - present_o and the debounce counters are retained.
  - If it drops mid-scan, the current scan completes, then the FSM holds.
- Counters are sized by $clog2 of the largest relevant parameter; none wraps.

## Timing
- Reset values: sense_oe=0, sense_o=0, present_o=0, change_o=0, scan_done_o=0, state=IDLE, all counters 0.
- rst_i asserted mid-scan: the FSM is in IDLE and sense_oe=0 from the next edge, and partial samples are discarded.
- Scan length from leaving IDLE to scan_done_o: (PRECHARGE_CYCLES if enabled) + SETTLE_CYCLES + 2 cycles.
- present_o and change_o update on the same edge as scan_done_o.
- sense_i is sampled exactly once per scan, in SAMPLE, i.e. SETTLE_CYCLES cycles after the last driven cycle.
- Worst-case presence latency after a board insertion: DEBOUNCE full scan periods.
- sense_oe never asserts outside PRECHARGE.

## Configuration
- DB_SENSE_PRECHARGE_EN defined: the PRECHARGE state exists. Each line is driven high before floating, so a present board must actively discharge it; a stuck-low fault shows as present only if genuinely pulled.
- DB_SENSE_PRECHARGE_EN undefined: PRECHARGE is removed, sense_o is tied 0 and sense_oe is tied 0 (the block is input-only).

## Structure
- db_sense_pkg holds:
  - the state encoding constants (IDLE, PRECHARGE, SETTLE, SAMPLE, UPDATE);
  - the debounce counter width constant (4 bits);
  - a clog2 helper.
- Sub-module db_sense_debounce: one channel's cnt/present register and flip pulse. It is instantiated NUM_DB times by a generate loop.

## Test plan
- Reset release, all slots pulled high: after 3 scans present_o=4'b0000, no change_o, sense_oe=0 except during precharge.
- Slot 2 pulled low from t=0, DEBOUNCE=3: present_o[2] rises on the 3rd scan_done_o, together with a single change_o pulse.
- Slot 0 glitch: low for 1 scan only, then high: present_o[0] stays 0 and cnt returns to 0.
- force_rescan_i pulsed 5 cycles into IDLE with SCAN_PERIOD=1024: the FSM leaves IDLE next cycle, and scan_done_o arrives SETTLE_CYCLES+2 (+PRECHARGE_CYCLES) cycles later.
- rst_i asserted during SETTLE with present_o=4'b0100: next cycle present_o=0, state=IDLE and sense_oe=0.
- enable_i low for 5000 cycles: no scan_done_o, present_o held. Scanning resumes SCAN_PERIOD cycles after enable_i rises.
